pic_command_regs: RTL and testbench

//   Downstream consumer of the 8259A read/write logic's ICW[3:0]/OCW[2:0] strobes and data bus.

---
 rtl/pic_command_regs.sv | 177 +++++++++++++++++
 tb/tb_pic_command_regs.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pic_command_regs.sv
// rtl/pic_command_regs.sv - 8259A ICW/OCW command register file and init sequencer
// Synchronises async write strobes, sequences ICW1..ICW4 and decodes OCW1..OCW3.
module pic_command_regs #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [1:0] RST_READ_SEL = 2'b10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] icw_strobe,
  input  logic [2:0] ocw_strobe,
  input  logic [7:0] din,
  output logic       init_done,
  output logic [4:0] vector_base,
  output logic       ltim,
  output logic       single_mode,
  output logic [7:0] cascade_id,
  output logic       aeoi,
  output logic [1:0] mstr_buf,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic [1:0] read_command,
  output logic       special_mask,
  output logic       rotate_aeoi,
  output logic       eoi_pulse,
  output logic       eoi_specific,
  output logic       eoi_rotate,
  output logic [2:0] eoi_level,
  output logic       set_prio_pulse,
  output logic       poll_pulse,
  output logic       protocol_err
);

  typedef enum logic [2:0] {UNINIT, W_ICW2, W_ICW3, W_ICW4, READY} state_t;

  state_t state_q, state_d;

  // Data travels through the same synchroniser as the strobes so both stay aligned.
  logic [14:0] sync_q [SYNC_STAGES];
  logic [6:0]  strb_prev_q;
  logic [6:0]  strb_s, rise, win;
  logic [7:0]  d;
  logic        ic4;
  logic        err_c;
  logic        do_icw1, do_icw2, do_icw3, do_icw4, do_ocw1, do_ocw2, do_ocw3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      strb_prev_q <= '0;
    end else begin
      sync_q[0] <= {din, ocw_strobe, icw_strobe};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      strb_prev_q <= strb_s;
    end
  end

  assign strb_s = sync_q[SYNC_STAGES-1][6:0];
  assign d      = sync_q[SYNC_STAGES-1][14:7];
  assign rise   = strb_s & ~strb_prev_q;
  // Bit 0 (ICW1) has highest priority; isolate the lowest set bit.
  assign win    = rise & (~rise + 7'd1);

  assign do_icw1 = win[0];
  assign do_icw2 = win[1] && (state_q == W_ICW2);
  assign do_icw3 = win[2] && (state_q == W_ICW3);
  assign do_icw4 = win[3] && (state_q == W_ICW4);
  assign do_ocw1 = win[4] && (state_q == READY);
  assign do_ocw2 = win[5] && (state_q == READY);
  assign do_ocw3 = win[6] && (state_q == READY);

  always_comb begin
    state_d = state_q;
    err_c   = |(rise & ~win);
    if (win[1] && state_q != W_ICW2) err_c = 1'b1;
    if (win[2] && state_q != W_ICW3) err_c = 1'b1;
    if (win[3] && state_q != W_ICW4) err_c = 1'b1;
    if ((|win[6:4]) && state_q != READY) err_c = 1'b1;
    if (do_icw1) begin
      state_d = W_ICW2;
    end else if (do_icw2) begin
      if (!single_mode) state_d = W_ICW3;
      else if (ic4)     state_d = W_ICW4;
      else              state_d = READY;
    end else if (do_icw3) begin
      state_d = ic4 ? W_ICW4 : READY;
    end else if (do_icw4) begin
      state_d = READY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= UNINIT;
    else        state_q <= state_d;
  end

  assign init_done = (state_q == READY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vector_base    <= '0;
      ltim           <= 1'b0;
      single_mode    <= 1'b0;
      ic4            <= 1'b0;
      cascade_id     <= '0;
      aeoi           <= 1'b0;
      mstr_buf       <= '0;
      sfnm           <= 1'b0;
      imr            <= '0;
      read_command   <= RST_READ_SEL;
      special_mask   <= 1'b0;
      rotate_aeoi    <= 1'b0;
      eoi_pulse      <= 1'b0;
      eoi_specific   <= 1'b0;
      eoi_rotate     <= 1'b0;
      eoi_level      <= 3'd7;
      set_prio_pulse <= 1'b0;
      poll_pulse     <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      eoi_pulse      <= 1'b0;
      eoi_specific   <= 1'b0;
      eoi_rotate     <= 1'b0;
      set_prio_pulse <= 1'b0;
      poll_pulse     <= 1'b0;
      protocol_err   <= err_c;
      if (do_icw1) begin
        ltim         <= d[3];
        single_mode  <= d[1];
        ic4          <= d[0];
        imr          <= '0;
        special_mask <= 1'b0;
        rotate_aeoi  <= 1'b0;
        read_command <= RST_READ_SEL;
        eoi_level    <= 3'd7;
      end
      if (do_icw2) begin
        vector_base <= d[7:3];
        if (single_mode && !ic4) begin
          aeoi     <= 1'b0;
          mstr_buf <= '0;
          sfnm     <= 1'b0;
        end
      end
      if (do_icw3) cascade_id <= d;
      if (do_icw4) begin
        aeoi     <= d[1];
        mstr_buf <= d[3:2];
        sfnm     <= d[4];
      end
      if (do_ocw1) imr <= d;
      if (do_ocw2) begin
        case (d[7:5])
          3'b001: eoi_pulse <= 1'b1;
          3'b011: begin eoi_pulse <= 1'b1; eoi_specific <= 1'b1; eoi_level <= d[2:0]; end
          3'b101: begin eoi_pulse <= 1'b1; eoi_rotate <= 1'b1; end
          3'b111: begin
            eoi_pulse    <= 1'b1;
            eoi_specific <= 1'b1;
            eoi_rotate   <= 1'b1;
            eoi_level    <= d[2:0];
          end
          3'b100: rotate_aeoi <= 1'b1;
          3'b000: rotate_aeoi <= 1'b0;
          3'b110: begin set_prio_pulse <= 1'b1; eoi_level <= d[2:0]; end
          default: ;
        endcase
      end
      if (do_ocw3) begin
        if (d[6:5] == 2'b11)      special_mask <= 1'b1;
        else if (d[6:5] == 2'b10) special_mask <= 1'b0;
        if (d[1]) read_command <= d[1:0];
        if (d[2]) poll_pulse <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pic_command_regs.sv
// tb/tb_pic_command_regs.sv - directed self-checking bench for pic_command_regs
// Strobe vector bit order: {OCW3,OCW2,OCW1,ICW4,ICW3,ICW2,ICW1}.
module tb_pic_command_regs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] icw_strobe;
  logic [2:0] ocw_strobe;
  logic [7:0] din;
  logic       init_done, ltim, single_mode, aeoi, sfnm, special_mask, rotate_aeoi;
  logic [4:0] vector_base;
  logic [7:0] cascade_id, imr;
  logic [1:0] mstr_buf, read_command;
  logic       eoi_pulse, eoi_specific, eoi_rotate, set_prio_pulse, poll_pulse, protocol_err;
  logic [2:0] eoi_level;

  int errors = 0;
  int checks = 0;

  int n_eoi, n_setp, n_poll, n_err, first_idx;
  logic       cap_spec, cap_rot;
  logic [2:0] cap_lvl;

  always #5 clk = ~clk;

  pic_command_regs dut (
    .clk(clk), .rst_n(rst_n), .icw_strobe(icw_strobe), .ocw_strobe(ocw_strobe), .din(din),
    .init_done(init_done), .vector_base(vector_base), .ltim(ltim), .single_mode(single_mode),
    .cascade_id(cascade_id), .aeoi(aeoi), .mstr_buf(mstr_buf), .sfnm(sfnm), .imr(imr),
    .read_command(read_command), .special_mask(special_mask), .rotate_aeoi(rotate_aeoi),
    .eoi_pulse(eoi_pulse), .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate),
    .eoi_level(eoi_level), .set_prio_pulse(set_prio_pulse), .poll_pulse(poll_pulse),
    .protocol_err(protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Hold the strobes for 6 clocks while counting 1-clock pulses, then release and settle.
  task automatic wr(input logic [6:0] strb, input logic [7:0] data);
    n_eoi = 0; n_setp = 0; n_poll = 0; n_err = 0; first_idx = -1;
    cap_spec = 1'b0; cap_rot = 1'b0; cap_lvl = 3'd0;
    @(negedge clk);
    din        = data;
    icw_strobe = strb[3:0];
    ocw_strobe = strb[6:4];
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (eoi_pulse) begin
        n_eoi++;
        cap_spec = eoi_specific; cap_rot = eoi_rotate; cap_lvl = eoi_level;
      end
      if (set_prio_pulse) n_setp++;
      if (poll_pulse) n_poll++;
      if (protocol_err) n_err++;
      if (first_idx < 0 && (eoi_pulse || set_prio_pulse || poll_pulse || protocol_err))
        first_idx = i;
    end
    icw_strobe = '0;
    ocw_strobe = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; icw_strobe = '0; ocw_strobe = '0; din = '0;
    repeat (3) @(negedge clk);
    chk("rst_imr", imr, 8'h00);
    chk("rst_read_command", read_command, 2'b10);
    chk("rst_eoi_level", eoi_level, 3'd7);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_pulses", {eoi_pulse, set_prio_pulse, poll_pulse, protocol_err, eoi_specific, eoi_rotate}, 6'b0);
    rst_n = 1'b1;

    // Single, ICW4 needed: no ICW3 wait.
    wr(7'h01, 8'h13);
    chk("t2_single", single_mode, 1'b1);
    chk("t2_init_after_icw1", init_done, 1'b0);
    wr(7'h02, 8'h48);
    chk("t2_vector_base", vector_base, 5'h09);
    chk("t2_init_after_icw2", init_done, 1'b0);
    wr(7'h08, 8'h03);
    chk("t2_aeoi", aeoi, 1'b1);
    chk("t2_mstr_buf", mstr_buf, 2'b00);
    chk("t2_init_done", init_done, 1'b1);
    wr(7'h04, 8'h77);
    chk("icw3_out_of_seq_err", n_err, 1);
    chk("icw3_out_of_seq_latency", first_idx, 3);
    chk("icw3_out_of_seq_cascade", cascade_id, 8'h00);
    wr(7'h10, 8'h5A);
    chk("imr_5a", imr, 8'h5A);

    // Cascade with ICW3 and ICW4.
    wr(7'h01, 8'h11);
    chk("t3_imr_cleared", imr, 8'h00);
    chk("t3_single", single_mode, 1'b0);
    wr(7'h02, 8'h20);
    chk("t3_vector_base", vector_base, 5'h04);
    wr(7'h04, 8'h04);
    chk("t3_cascade_id", cascade_id, 8'h04);
    chk("t3_not_ready_before_icw4", init_done, 1'b0);
    wr(7'h08, 8'h01);
    chk("t3_init_done", init_done, 1'b1);
    chk("t3_aeoi", aeoi, 1'b0);
    chk("t3_no_err", n_err, 0);

    // OCW2 decode.
    wr(7'h20, 8'h63);
    chk("ocw2_63_eoi_cnt", n_eoi, 1);
    chk("ocw2_63_qual", {cap_spec, cap_rot, cap_lvl}, {1'b1, 1'b0, 3'd3});
    chk("ocw2_63_spec_after", eoi_specific, 1'b0);
    wr(7'h20, 8'hC5);
    chk("ocw2_c5_setp_cnt", n_setp, 1);
    chk("ocw2_c5_no_eoi", n_eoi, 0);
    chk("ocw2_c5_level", eoi_level, 3'd5);
    wr(7'h20, 8'hA2);
    chk("ocw2_a2_qual", {n_eoi[3:0], cap_spec, cap_rot, cap_lvl}, {4'd1, 1'b0, 1'b1, 3'd5});
    wr(7'h20, 8'h80);
    chk("ocw2_80_rotate_aeoi", rotate_aeoi, 1'b1);
    wr(7'h20, 8'h00);
    chk("ocw2_00_rotate_aeoi", rotate_aeoi, 1'b0);

    // OCW3 and OCW1.
    wr(7'h40, 8'h0B);
    chk("ocw3_0b_read_command", read_command, 2'b11);
    wr(7'h40, 8'h6C);
    chk("ocw3_6c_special_mask", special_mask, 1'b1);
    chk("ocw3_6c_poll_cnt", n_poll, 1);
    chk("ocw3_6c_read_command_kept", read_command, 2'b11);
    wr(7'h10, 8'hA5);
    chk("ocw1_imr", imr, 8'hA5);

    // Async reset discards state; OCW before init is rejected.
    @(negedge clk); rst_n = 1'b0; #2;
    chk("rst2_init_done", init_done, 1'b0);
    chk("rst2_imr", imr, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    wr(7'h10, 8'hFF);
    chk("ocw1_pre_init_imr", imr, 8'h00);
    chk("ocw1_pre_init_err", n_err, 1);
    wr(7'h11, 8'h1A);
    chk("icw1_ocw1_err", n_err, 1);
    chk("icw1_ocw1_imr", imr, 8'h00);
    chk("icw1_ocw1_ltim", ltim, 1'b1);
    wr(7'h02, 8'h50);
    chk("single_no_ic4_ready", init_done, 1'b1);
    chk("single_no_ic4_vector", vector_base, 5'h0A);
    chk("single_no_ic4_aeoi", aeoi, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
